// File: rtl/ftdi_fifo_bridge.sv
// ftdi_fifo_bridge: buffered FT245-style FIFO bridge with fair TX/RX burst arbitration
module ftdi_fifo_bridge #(
  parameter int DATA_W       = 8,
  parameter int TX_DEPTH     = 16,
  parameter int RX_DEPTH     = 16,
  parameter int T_RD_ACTIVE  = 4,
  parameter int T_RD_SAMPLE  = 3,
  parameter int T_DATA_TO_WR = 2,
  parameter int T_WR_ACTIVE  = 4,
  parameter int T_RECOVER    = 1,
  parameter int MAX_BURST    = 4
) (
  input  logic                          in_clk,
  input  logic                          in_rst,
  input  logic                          in_ftdi_txe,
  input  logic                          in_ftdi_rxf,
  inout  wire  [DATA_W-1:0]             io_ftdi_data,
  output logic                          out_ftdi_wr,
  output logic                          out_ftdi_rd,
  input  logic                          in_rx_ena,
  input  logic [DATA_W-1:0]             in_tx_data,
  input  logic                          in_tx_valid,
  output logic                          out_tx_ready,
  output logic [DATA_W-1:0]             out_rx_data,
  output logic                          out_rx_valid,
  input  logic                          in_rx_ready,
  output logic [$clog2(TX_DEPTH):0]     out_tx_level,
  output logic [$clog2(RX_DEPTH):0]     out_rx_level
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int BW  = $clog2(MAX_BURST + 1);
  localparam logic [15:0] RD_LAST = 16'(T_RD_ACTIVE - 1);
  localparam logic [15:0] RD_SMP  = 16'(T_RD_SAMPLE);
  localparam logic [15:0] SU_LAST = 16'(T_DATA_TO_WR - 1);
  localparam logic [15:0] WR_LAST = 16'(T_WR_ACTIVE - 1);
  localparam logic [15:0] RC_LAST = 16'(T_RECOVER - 1);
  localparam logic [BW-1:0] BMAX  = BW'(MAX_BURST);

  typedef enum logic [2:0] {IDLE, RD_PULSE, WR_SETUP, WR_PULSE, RECOVER} state_t;

  state_t            state;
  logic [15:0]       cnt;
  logic              oe;
  logic [DATA_W-1:0] dout;
  logic [DATA_W-1:0] cap;
  logic [BW-1:0]     burst;
  logic              last_rx;

  logic [DATA_W-1:0] tx_mem [TX_DEPTH];
  logic [TAW-1:0]    tx_wp, tx_rp;
  logic [TAW:0]      tx_lvl;
  logic [DATA_W-1:0] rx_mem [RX_DEPTH];
  logic [RAW-1:0]    rx_wp, rx_rp;
  logic [RAW:0]      rx_lvl;

  logic              tx_push, tx_pop, rx_push, rx_pop;
  logic              rx_ok, tx_ok, pick_rx;
  logic [BW-1:0]     burst_nxt;
  logic [DATA_W-1:0] rx_din;

  assign io_ftdi_data = oe ? dout : 'z;
  assign out_tx_ready = tx_lvl != (TAW+1)'(TX_DEPTH);
  assign out_rx_valid = rx_lvl != '0;
  assign out_rx_data  = out_rx_valid ? rx_mem[rx_rp] : '0;
  assign out_tx_level = tx_lvl;
  assign out_rx_level = rx_lvl;

  // FIFO handshakes, eligibility and burst-fairness arbitration
  always_comb begin
    tx_push   = in_tx_valid && out_tx_ready;
    tx_pop    = state == WR_PULSE && cnt == WR_LAST;
    rx_push   = state == RD_PULSE && cnt == RD_LAST;
    rx_pop    = out_rx_valid && in_rx_ready;
    rx_din    = cnt == RD_SMP ? io_ftdi_data : cap;
    rx_ok     = in_rx_ena && in_ftdi_rxf && rx_lvl != (RAW+1)'(RX_DEPTH);
    tx_ok     = in_ftdi_txe && tx_lvl != '0;
    pick_rx   = rx_ok && (!tx_ok || (burst < BMAX ? last_rx : !last_rx));
    burst_nxt = pick_rx != last_rx ? BW'(1) : (burst == BMAX ? burst : burst + 1'b1);
  end

  // FIFO storage, written without reset since occupancy gates every read
  always_ff @(posedge in_clk) begin
    if (tx_push) tx_mem[tx_wp] <= in_tx_data;
    if (rx_push) rx_mem[rx_wp] <= rx_din;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_lvl <= '0;
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_lvl <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop) tx_rp <= tx_rp + 1'b1;
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop) rx_rp <= rx_rp + 1'b1;
      tx_lvl <= tx_lvl + (TAW+1)'(tx_push) - (TAW+1)'(tx_pop);
      rx_lvl <= rx_lvl + (RAW+1)'(rx_push) - (RAW+1)'(rx_pop);
    end
  end

  // Transfer sequencer with registered strobes and bus enable
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      out_ftdi_rd <= 1'b0;
      out_ftdi_wr <= 1'b0;
      oe          <= 1'b0;
      burst       <= '0;
      last_rx     <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (rx_ok || tx_ok) begin
            cnt     <= '0;
            burst   <= burst_nxt;
            last_rx <= pick_rx;
            if (pick_rx) begin
              out_ftdi_rd <= 1'b1;
              state       <= RD_PULSE;
            end else begin
              dout  <= tx_mem[tx_rp];
              oe    <= 1'b1;
              state <= WR_SETUP;
            end
          end
        RD_PULSE: begin
          if (cnt == RD_SMP) cap <= io_ftdi_data;
          if (cnt == RD_LAST) begin
            out_ftdi_rd <= 1'b0;
            cnt         <= '0;
            state       <= RECOVER;
          end else cnt <= cnt + 1'b1;
        end
        WR_SETUP:
          if (cnt == SU_LAST) begin
            out_ftdi_wr <= 1'b1;
            cnt         <= '0;
            state       <= WR_PULSE;
          end else cnt <= cnt + 1'b1;
        WR_PULSE:
          if (cnt == WR_LAST) begin
            out_ftdi_wr <= 1'b0;
            oe          <= 1'b0;
            cnt         <= '0;
            state       <= RECOVER;
          end else cnt <= cnt + 1'b1;
        RECOVER:
          if (cnt == RC_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
